// File: rtl/lock_sequencer.sv
// PLL lock sequencer: syncs locked, holds off for HOLD cycles, then releases rst_n and strobes ce every CEDIV cycles.
// Release HOLD+2 edges after locked is sampled, loss after 2; no backpressure; LOCK_SEQ_FAULT_LATCH_EN latches loss in FAULT.
module lock_sequencer #(
  parameter int HOLD  = 24000,
  parameter int CEDIV = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic locked,
  output logic rst_n,
  output logic ready,
  output logic ce,
  output logic lost
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int CW = (CEDIV > 1) ? $clog2(CEDIV) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [CW-1:0] CE_LAST   = CW'(CEDIV - 1);

`ifdef LOCK_SEQ_FAULT_LATCH_EN
  typedef enum logic [1:0] {IDLE, COUNT, RUN, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, COUNT, RUN} state_t;
`endif

  logic          s1, s2;
  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic [CW-1:0] ce_cnt, ce_cnt_nxt;
  logic          run_nxt, ce_nxt, lost_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= locked;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      ce_cnt   <= '0;
      rst_n    <= 1'b0;
      ready    <= 1'b0;
      ce       <= 1'b0;
      lost     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      ce_cnt   <= ce_cnt_nxt;
      rst_n    <= run_nxt;
      ready    <= run_nxt;
      ce       <= ce_nxt;
      lost     <= lost_nxt;
    end
  end

  // A drop of s2 in COUNT wins over the terminal count.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        hold_cnt_nxt = '0;
        if (s2) state_nxt = COUNT;
      end
      COUNT: begin
        if (!s2) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end else begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
      RUN: begin
        if (!s2) begin
`ifdef LOCK_SEQ_FAULT_LATCH_EN
          state_nxt = FAULT;
`else
          state_nxt = IDLE;
`endif
          hold_cnt_nxt = '0;
        end
      end
`ifdef LOCK_SEQ_FAULT_LATCH_EN
      FAULT: state_nxt = FAULT;
`endif
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they change on the same edge as the state.
  always_comb begin
    run_nxt    = (state_nxt == RUN);
    ce_cnt_nxt = '0;
    ce_nxt     = 1'b0;
    if (run_nxt) begin
      if (state != RUN || ce_cnt == CE_LAST) ce_cnt_nxt = '0;
      else                                   ce_cnt_nxt = ce_cnt + CW'(1);
      ce_nxt = (ce_cnt_nxt == '0);
    end
`ifdef LOCK_SEQ_FAULT_LATCH_EN
    lost_nxt = (state_nxt == FAULT);
`else
    lost_nxt = (state == RUN) && !run_nxt;
`endif
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: three instances (HOLD/CEDIV = 4/3, 1/1, 8/3) on one clock.
module tb_lock_sequencer;

`ifdef LOCK_SEQ_FAULT_LATCH_EN
  localparam logic FAULT_LATCH = 1'b1;
`else
  localparam logic FAULT_LATCH = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_a, reset_b, reset_c;
  logic locked_a, locked_b, locked_c;
  logic rst_n_a, ready_a, ce_a, lost_a;
  logic rst_n_b, ready_b, ce_b, lost_b;
  logic rst_n_c, ready_c, ce_c, lost_c;

  int nvec   = 0;
  int nerr   = 0;
  int ecount = 0;
  int e0, e1;

  always #5 clock = ~clock;

  lock_sequencer #(.HOLD(4), .CEDIV(3)) dut_a (
    .clock(clock), .reset(reset_a), .locked(locked_a),
    .rst_n(rst_n_a), .ready(ready_a), .ce(ce_a), .lost(lost_a));

  lock_sequencer #(.HOLD(1), .CEDIV(1)) dut_b (
    .clock(clock), .reset(reset_b), .locked(locked_b),
    .rst_n(rst_n_b), .ready(ready_b), .ce(ce_b), .lost(lost_b));

  lock_sequencer #(.HOLD(8), .CEDIV(3)) dut_c (
    .clock(clock), .reset(reset_c), .locked(locked_c),
    .rst_n(rst_n_c), .ready(ready_c), .ce(ce_c), .lost(lost_c));

  task automatic tick();
    @(posedge clock);
    #1;
    ecount++;
  endtask

  task automatic run_to(input int n);
    while (ecount < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_cleared(input string tag);
    chk({tag, " rst_n"}, 32'(rst_n_a), 0);
    chk({tag, " ready"}, 32'(ready_a), 0);
    chk({tag, " ce"},    32'(ce_a), 0);
    chk({tag, " lost"},  32'(lost_a), 0);
    chk({tag, " s1"},    32'(dut_a.s1), 0);
    chk({tag, " s2"},    32'(dut_a.s2), 0);
    chk({tag, " hold_cnt"}, 32'(dut_a.hold_cnt), 0);
    chk({tag, " ce_cnt"},   32'(dut_a.ce_cnt), 0);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    locked_a = 1'b0; locked_b = 1'b0; locked_c = 1'b0;
    #1;
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    #1;
    chk_a_cleared("por_a");
    chk("por_b rst_n", 32'(rst_n_b), 0);
    chk("por_b ce",    32'(ce_b), 0);
    chk("por_c rst_n", 32'(rst_n_c), 0);
    chk("por_c lost",  32'(lost_c), 0);
    #1;
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;

    // HOLD=1, CEDIV=1: locked sampled at edge 5 -> RUN after edge 8.
    run_to(4); locked_b = 1'b1;
    run_to(7); chk("b pre rst_n", 32'(rst_n_b), 0);
    run_to(8);
    chk("b rel rst_n", 32'(rst_n_b), 1);
    chk("b rel ready", 32'(ready_b), 1);
    chk("b rel ce",    32'(ce_b), 1);
    chk("b rel lost",  32'(lost_b), 0);

    // A and C: locked sampled from edge 10.
    run_to(9); locked_a = 1'b1; locked_c = 1'b1;
    chk("b ce run 9", 32'(ce_b), 1);
    for (int e = 10; e <= 12; e++) begin
      run_to(e);
      chk("b ce run", 32'(ce_b), 1);
    end

    // C glitch: locked low only at edge 15.
    run_to(14); locked_c = 1'b0;
    run_to(15); locked_c = 1'b1;
    chk("a pre rst_n", 32'(rst_n_a), 0);
    chk("a pre ready", 32'(ready_a), 0);

    for (int e = 16; e <= 24; e++) begin
      run_to(e);
      chk("a run rst_n", 32'(rst_n_a), 1);
      chk("a run ce", 32'(ce_a), ((e - 16) % 3 == 0) ? 1 : 0);
      if (e == 20) chk("c no early release", 32'(rst_n_c), 0);
    end
    locked_a = 1'b0;

    run_to(25); chk("c pre rst_n", 32'(rst_n_c), 0);
    run_to(26);
    chk("c rel rst_n", 32'(rst_n_c), 1);
    chk("c rel ce",    32'(ce_c), 1);
    chk("a loss+1 rst_n", 32'(rst_n_a), 1);
    run_to(27);
    chk("a loss rst_n", 32'(rst_n_a), 0);
    chk("a loss ready", 32'(ready_a), 0);
    chk("a loss ce",    32'(ce_a), 0);
    chk("a loss lost",  32'(lost_a), 1);
    run_to(28);
    chk("a lost next", 32'(lost_a), 32'(FAULT_LATCH));
    chk("a loss rst_n hold", 32'(rst_n_a), 0);
    run_to(29); chk("c ce period", 32'(ce_c), 1);
    run_to(30); locked_a = 1'b1;

`ifdef LOCK_SEQ_FAULT_LATCH_EN
    run_to(37);
    chk("a fault rst_n", 32'(rst_n_a), 0);
    chk("a fault lost",  32'(lost_a), 1);
    run_to(131);
    chk("a fault late rst_n", 32'(rst_n_a), 0);
    chk("a fault late ready", 32'(ready_a), 0);
    chk("a fault late lost",  32'(lost_a), 1);
    run_to(135);
`else
    run_to(36); chk("a rearm pre rst_n", 32'(rst_n_a), 0);
    run_to(37);
    chk("a rearm rst_n", 32'(rst_n_a), 1);
    chk("a rearm ce",    32'(ce_a), 1);
    chk("a rearm lost",  32'(lost_a), 0);
    run_to(38); chk("a rearm ce 38", 32'(ce_a), 0);
    run_to(41);
    chk("a rearm ce 41", 32'(ce_a), 0);
    chk("a ce_cnt 41", 32'(dut_a.ce_cnt), 1);
`endif

    // Asynchronous reset between edges, then fresh sequencing with locked already high.
    e0 = ecount;
    #2 reset_a = 1'b0;
    #1 chk_a_cleared("async run");
    #2 reset_a = 1'b1;

    run_to(e0 + 4);
    chk("a count hold_cnt", 32'(dut_a.hold_cnt), 1);
    chk("a count rst_n", 32'(rst_n_a), 0);
    #2 reset_a = 1'b0;
    #1 chk_a_cleared("async count");
    #2 reset_a = 1'b1;

    e1 = ecount;
    run_to(e1 + 6); chk("a reseq pre rst_n", 32'(rst_n_a), 0);
    run_to(e1 + 7);
    chk("a reseq rst_n", 32'(rst_n_a), 1);
    chk("a reseq ready", 32'(ready_a), 1);
    chk("a reseq ce",    32'(ce_a), 1);
    chk("a reseq lost",  32'(lost_a), 0);
    run_to(e1 + 8);  chk("a reseq ce +1", 32'(ce_a), 0);
    run_to(e1 + 10); chk("a reseq ce +3", 32'(ce_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
